uart_cfg_rx: RTL

UART_CFG_RX -- requirements
Module: uart_cfg_rx

---
 rtl/uart_cfg_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 147 ++++++++++++++
 rtl/uart_cfg_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared constants, FSM state type and parity helper for the UART configuration receiver.
// The optional parity stage is enabled with the UART_CFG_PARITY_EN macro.
package uart_cfg_pkg;

   localparam int DATA_BITS  = 8;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte UART receiver: input synchronizer, frame state machine and bit timing.
// Macro UART_CFG_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_rx_byte
   import uart_cfg_pkg::*;
#(
   parameter int UART_DIV = 8
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] byte_o,
   output logic                 byte_valid_o,
   output logic                 frame_err_o,
   output logic                 busy_o
);

   localparam logic [15:0] HALF_LOAD = 16'(UART_DIV / 2 - 1);
   localparam logic [15:0] BIT_LOAD  = 16'(UART_DIV - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   rx_state_e            state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [2:0]           bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 stopOk;
`ifdef UART_CFG_PARITY_EN
   logic                 parErr_q, parErr_d;
`endif

   // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
`ifdef UART_CFG_PARITY_EN
         parErr_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
`ifdef UART_CFG_PARITY_EN
         parErr_q <= parErr_d;
`endif
      end
   end

   // A sample is taken whenever the bit counter has run down to zero.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bitIdx_d     = bitIdx_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
`ifdef UART_CFG_PARITY_EN
      parErr_d     = parErr_q;
      stopOk       = sync2_q && !parErr_q;
`else
      stopOk       = sync2_q;
`endif
      case (state_q)
         IDLE: begin
            if (!sync2_q) begin
               state_d = START;
               cnt_d   = HALF_LOAD;
            end
         end
         START: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!sync2_q) begin
               state_d  = DATA;
               cnt_d    = BIT_LOAD;
               bitIdx_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shift_d  = {sync2_q, shift_q[DATA_BITS-1:1]};
               cnt_d    = BIT_LOAD;
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == LAST_BIT) begin
`ifdef UART_CFG_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_CFG_PARITY_EN
         PARITY: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               parErr_d = sync2_q ^ evenParity(shift_q);
               cnt_d    = BIT_LOAD;
               state_d  = STOP;
            end
         end
`endif
         // Leave at mid stop bit so a following start edge is never missed.
         STOP: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               if (stopOk) begin
                  byte_valid_o = 1'b1;
               end else begin
                  frame_err_o = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign byte_o = shift_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_cfg_rx.sv
// UART configuration receiver: gathers four bytes big-endian into a 32-bit word and drops stale partial words.
// Build with UART_CFG_PARITY_EN to expect an even-parity bit in every frame.
module uart_cfg_rx
   import uart_cfg_pkg::*;
#(
   parameter int UART_DIV     = 8,
   parameter int IDLE_TIMEOUT = 64
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        Rx,
   output logic [31:0] WriteData,
   output logic        WriteStrobe,
   output logic        ComActive,
   output logic        ReceiveLED,
   output logic        FrameErr
);

   localparam int          PART_W       = (WORD_BYTES - 1) * DATA_BITS;
   localparam logic [1:0]  LAST_IDX     = 2'(WORD_BYTES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(IDLE_TIMEOUT * UART_DIV - 1);

   logic [DATA_BITS-1:0] rxByte;
   logic                 byteValid;
   logic                 frameErrRaw;
   logic                 busy;

   logic [1:0]        idx_q, idx_d;
   logic [PART_W-1:0] partial_q, partial_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              strobe_q, strobe_d;
   logic              ferr_q, ferr_d;
   logic [31:0]       idleCnt_q, idleCnt_d;

   uart_rx_byte #(
      .UART_DIV(UART_DIV)
   ) u_rx_byte (
      .clk_i        (CLK),
      .rst_i        (RST),
      .rx_i         (Rx),
      .byte_o       (rxByte),
      .byte_valid_o (byteValid),
      .frame_err_o  (frameErrRaw),
      .busy_o       (busy)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q     <= '0;
         partial_q <= '0;
         wdata_q   <= '0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
         idleCnt_q <= '0;
      end else begin
         idx_q     <= idx_d;
         partial_q <= partial_d;
         wdata_q   <= wdata_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
         idleCnt_q <= idleCnt_d;
      end
   end

   // Earlier bytes shift up through the partial register so the first byte lands in the top lane.
   always_comb begin
      idx_d     = idx_q;
      partial_d = partial_q;
      wdata_d   = wdata_q;
      strobe_d  = 1'b0;
      ferr_d    = 1'b0;
      idleCnt_d = '0;
      if (frameErrRaw) begin
         ferr_d = 1'b1;
         idx_d  = '0;
      end else if (byteValid) begin
         if (idx_q == LAST_IDX) begin
            wdata_d  = {partial_q, rxByte};
            strobe_d = 1'b1;
            idx_d    = '0;
         end else begin
            partial_d = {partial_q[PART_W-DATA_BITS-1:0], rxByte};
            idx_d     = idx_q + 2'd1;
         end
      end else if (!busy && (idx_q != 2'd0)) begin
         if (idleCnt_q == TIMEOUT_LAST) begin
            idx_d = '0;
         end else begin
            idleCnt_d = idleCnt_q + 32'd1;
         end
      end
   end

   assign WriteData   = wdata_q;
   assign WriteStrobe = strobe_q;
   assign FrameErr    = ferr_q;
   assign ComActive   = (idx_q != 2'd0);
   assign ReceiveLED  = busy;

endmodule
